// File: rtl/sram_cmd_sequencer.sv
// sram_cmd_sequencer: buffers client read/write requests in a small FIFO and
// replays them to sram_controller as single-cycle strobes with a minimum idle
// gap between commands. Read data is captured a fixed latency after the read
// strobe and returned as a one-cycle response pulse.
module sram_cmd_sequencer #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 4,
  parameter int RD_LAT  = 2,
  parameter int GAP_CYC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              read_enable,
  output logic              write_enable_in,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] write_data,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_MAX = (RD_LAT > GAP_CYC) ? RD_LAT : GAP_CYC;
  localparam int TMR_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, GAP} state_t;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } entry_t;

  entry_t           fifo_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  state_t           state;
  state_t           state_nx;
  logic [TMR_W-1:0] timer;
  logic             cur_write;
  logic             rd_sample;

  assign full      = (count == (PTR_W + 1)'(DEPTH));
  assign empty     = (count == '0);
  assign req_ready = !full;
  // Push only when not full, even if a pop frees a slot this cycle (no bypass).
  assign push      = req_valid & !full;
  assign pop       = (state == IDLE) & !empty;
  // Last WAIT_RD cycle: the SRAM byte is valid on mem_rdata at this edge.
  assign rd_sample = (state == WAIT_RD) && (timer == '0);

  // FIFO storage: written on push only.
  // NOTE: the storage array has no reset; validity is tracked solely by count,
  // so stale entries are never observable and the array can map to plain RAM.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= '{write: req_write, addr: req_addr, wdata: req_wdata};
  end

  // FIFO pointers and occupancy; push+pop together leaves count unchanged.
  // NOTE: every sequential block uses non-blocking assignments so all
  // registers update from pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic.
  // NOTE: combinational blocks assign a default first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (!empty) state_nx = ISSUE;
      ISSUE:   state_nx = cur_write ? GAP : WAIT_RD;
      WAIT_RD: if (timer == '0) state_nx = GAP;
      GAP:     if (timer == '0) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Down-counter for read latency and the inter-command gap, loaded on entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer <= '0;
    end else begin
      case (state)
        ISSUE:   timer <= cur_write ? TMR_W'(GAP_CYC - 1) : TMR_W'(RD_LAT - 1);
        WAIT_RD: timer <= (timer == '0) ? TMR_W'(GAP_CYC - 1) : timer - 1'b1;
        GAP:     if (timer != '0) timer <= timer - 1'b1;
        default: timer <= timer;
      endcase
    end
  end

  // Command registers (change only on a pop) and read-response capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_write  <= 1'b0;
      address    <= '0;
      write_data <= '0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
    end else begin
      rsp_valid <= rd_sample;
      if (rd_sample) rsp_rdata <= mem_rdata;
      if (pop) begin
        cur_write  <= fifo_mem[rd_ptr].write;
        address    <= fifo_mem[rd_ptr].addr;
        write_data <= fifo_mem[rd_ptr].wdata;
      end
    end
  end

  // Outputs: exactly one strobe during ISSUE, selected by the command type.
  always_comb begin
    read_enable     = 1'b0;
    write_enable_in = 1'b0;
    if (state == ISSUE) begin
      read_enable     = !cur_write;
      write_enable_in = cur_write;
    end
    busy = (state != IDLE) | !empty;
  end

endmodule

// File: tb/tb_sram_cmd_sequencer.sv
// Testbench for sram_cmd_sequencer: a table of per-cycle vectors for the basic
// write/read latency, hand-written multi-cycle sequences, and a randomized
// phase, all checked against a transaction-level reference model.
module tb_sram_cmd_sequencer;

  localparam int DEPTH   = 4;
  localparam int RD_LAT  = 2;
  localparam int GAP_CYC = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [15:0] req_addr = '0;
  logic [7:0]  req_wdata = '0;
  logic [7:0]  mem_rdata = '0;
  logic        req_ready, rsp_valid, read_enable, write_enable_in, busy;
  logic [7:0]  rsp_rdata, write_data;
  logic [15:0] address;

  sram_cmd_sequencer #(.ADDR_W(16), .DATA_W(8), .DEPTH(DEPTH), .RD_LAT(RD_LAT), .GAP_CYC(GAP_CYC)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .read_enable(read_enable), .write_enable_in(write_enable_in),
    .address(address), .write_data(write_data),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [7:0] init_val(input int a);
    return 8'(a) ^ 8'(a >> 8) ^ 8'h5C;
  endfunction

  // ---------------- behavioural SRAM (device side) ----------------
  logic [7:0]  sram [int];
  bit          rd_hist [RD_LAT+1];
  logic [15:0] a_hist  [RD_LAT+1];

  // Data is driven only in the cycle RD_LAT after the read strobe; garbage otherwise.
  always @(negedge clk) begin
    for (int k = RD_LAT; k > 0; k--) begin
      rd_hist[k] = rd_hist[k-1];
      a_hist[k]  = a_hist[k-1];
    end
    rd_hist[0] = (read_enable === 1'b1);
    a_hist[0]  = address;
    if (write_enable_in === 1'b1) sram[int'(address)] = write_data;
    if (rd_hist[RD_LAT])
      mem_rdata = sram.exists(int'(a_hist[RD_LAT])) ? sram[int'(a_hist[RD_LAT])] : init_val(int'(a_hist[RD_LAT]));
    else
      mem_rdata = 8'($urandom);
  end

  // ---------------- reference model (transaction level) ----------------
  typedef struct {int acc; bit write; logic [15:0] addr; logic [7:0] wdata;} req_t;
  typedef struct {int due; logic [7:0] data;} rsp_t;

  req_t        q[$];
  rsp_t        rq[$];
  logic [7:0]  ref_mem [int];
  int          next_free = 0;
  int          busy_until = -1;
  logic [15:0] last_addr = '0;
  logic [7:0]  last_wd = '0;
  bit          last_was_wr = 1'b1;
  bit          mon_en = 1'b0;

  function automatic logic [7:0] ref_rd(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  always @(negedge clk) begin : monitor
    int   exp_s;
    req_t r;
    rsp_t p;
    if (mon_en) begin
      check("no_overlap", {31'd0, read_enable & write_enable_in}, 32'd0);
      exp_s = -1;
      if (q.size() > 0) begin
        exp_s = q[0].acc + 2;
        if (next_free > exp_s) exp_s = next_free;
      end
      if (read_enable | write_enable_in) begin
        if (q.size() == 0) begin
          check("unexpected_strobe", 32'd1, 32'd0);
        end else begin
          r = q.pop_front();
          check("strobe_cycle", cyc, exp_s);
          check("strobe_kind", {31'd0, write_enable_in}, {31'd0, r.write});
          check("strobe_addr", {16'd0, address}, {16'd0, r.addr});
          last_addr   = r.addr;
          last_was_wr = r.write;
          last_wd     = r.wdata;
          if (r.write) begin
            ref_mem[int'(r.addr)] = r.wdata;
            next_free = cyc + GAP_CYC + 2;
          end else begin
            rq.push_back('{cyc + RD_LAT + 1, ref_rd(int'(r.addr))});
            next_free = cyc + RD_LAT + GAP_CYC + 2;
          end
          busy_until = next_free - 2;
        end
      end else if (exp_s == cyc) begin
        check("missing_strobe", 32'd0, 32'd1);
        void'(q.pop_front());
      end
      check("req_ready", {31'd0, req_ready}, {31'd0, q.size() < DEPTH});
      check("busy", {31'd0, busy}, {31'd0, (q.size() > 0) || (cyc <= busy_until)});
      check("address_hold", {16'd0, address}, {16'd0, last_addr});
      if (last_was_wr) check("write_data_hold", {24'd0, write_data}, {24'd0, last_wd});
      if (rsp_valid) begin
        if (rq.size() == 0) begin
          check("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          p = rq.pop_front();
          check("rsp_cycle", cyc, p.due);
          check("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, p.data});
        end
      end else if (rq.size() > 0 && rq[0].due == cyc) begin
        check("missing_rsp", 32'd0, 32'd1);
        void'(rq.pop_front());
      end
      if (rst) begin
        q.delete();
        rq.delete();
        next_free   = 0;
        busy_until  = -1;
        last_addr   = '0;
        last_wd     = '0;
        last_was_wr = 1'b1;
      end else if (req_valid && req_ready) begin
        q.push_back('{cyc, req_write, req_addr, req_wdata});
      end
    end
  end

  // Observation helpers for the hand-written sequences.
  bit         saw_full = 1'b0;
  int         rsp_count = 0;
  int         strobe_count = 0;
  logic [7:0] last_rsp = '0;
  always @(negedge clk) begin
    if (req_ready === 1'b0) saw_full = 1'b1;
    if (rsp_valid === 1'b1) begin rsp_count++; last_rsp = rsp_rdata; end
    if (read_enable === 1'b1 || write_enable_in === 1'b1) strobe_count++;
  end

  // ---------------- stimulus helpers (called at posedge+1) ----------------
  task automatic send(input bit w, input logic [15:0] a, input logic [7:0] d);
    bit done = 1'b0;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (req_ready) done = 1'b1;
      @(posedge clk); #1;
    end
    if (!done) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    bit done = 1'b0;
    req_valid = 1'b0;
    for (int k = 0; k < 500 && !done; k++) begin
      @(negedge clk);
      if (!busy && rq.size() == 0 && q.size() == 0) done = 1'b1;
    end
    if (!done) check("drain_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit rst, v, w; logic [15:0] a; logic [7:0] d;
    bit e_rdy, e_busy, e_re, e_we, e_rsp; logic [15:0] e_addr; logic [7:0] e_dat;
  } vec_t;
  vec_t vt[$];

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int rc0, sc0;
    //          rst v w addr    data   rdy bsy re we rsp addr    dat
    vt.push_back('{1, 0, 0, 16'h0000, 8'h00, 1, 0, 0, 0, 0, 16'h0000, 8'h00});
    vt.push_back('{0, 0, 0, 16'h0000, 8'h00, 1, 0, 0, 0, 0, 16'h0000, 8'h00});
    vt.push_back('{0, 0, 0, 16'h0000, 8'h00, 1, 0, 0, 0, 0, 16'h0000, 8'h00});
    vt.push_back('{0, 1, 1, 16'h0010, 8'hAA, 1, 0, 0, 0, 0, 16'h0000, 8'h00});
    vt.push_back('{0, 0, 0, 16'h0000, 8'h00, 1, 1, 0, 0, 0, 16'h0000, 8'h00});
    vt.push_back('{0, 0, 0, 16'h0000, 8'h00, 1, 1, 0, 1, 0, 16'h0010, 8'hAA});
    vt.push_back('{0, 0, 0, 16'h0000, 8'h00, 1, 1, 0, 0, 0, 16'h0010, 8'h00});
    vt.push_back('{0, 1, 0, 16'h0010, 8'h00, 1, 0, 0, 0, 0, 16'h0010, 8'h00});
    vt.push_back('{0, 0, 0, 16'h0000, 8'h00, 1, 1, 0, 0, 0, 16'h0010, 8'h00});
    vt.push_back('{0, 0, 0, 16'h0000, 8'h00, 1, 1, 1, 0, 0, 16'h0010, 8'h00});
    vt.push_back('{0, 0, 0, 16'h0000, 8'h00, 1, 1, 0, 0, 0, 16'h0010, 8'h00});
    vt.push_back('{0, 0, 0, 16'h0000, 8'h00, 1, 1, 0, 0, 0, 16'h0010, 8'h00});
    vt.push_back('{0, 0, 0, 16'h0000, 8'h00, 1, 1, 0, 0, 1, 16'h0010, 8'hAA});
    vt.push_back('{0, 0, 0, 16'h0000, 8'h00, 1, 0, 0, 0, 0, 16'h0010, 8'h00});
    vt.push_back('{0, 0, 0, 16'h0000, 8'h00, 1, 0, 0, 0, 0, 16'h0010, 8'h00});

    // Power-on reset: two edges with rst high before the table starts.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b1;

    // Tests 1-3: reset state, single write latency, read-back latency.
    for (int i = 0; i < vt.size(); i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      rst = vt[i].rst; req_valid = vt[i].v; req_write = vt[i].w;
      req_addr = vt[i].a; req_wdata = vt[i].d;
      @(negedge clk);
      check($sformatf("vec%0d_ready", i), {31'd0, req_ready}, {31'd0, vt[i].e_rdy});
      check($sformatf("vec%0d_busy", i), {31'd0, busy}, {31'd0, vt[i].e_busy});
      check($sformatf("vec%0d_re", i), {31'd0, read_enable}, {31'd0, vt[i].e_re});
      check($sformatf("vec%0d_we", i), {31'd0, write_enable_in}, {31'd0, vt[i].e_we});
      check($sformatf("vec%0d_rsp", i), {31'd0, rsp_valid}, {31'd0, vt[i].e_rsp});
      check($sformatf("vec%0d_addr", i), {16'd0, address}, {16'd0, vt[i].e_addr});
      if (vt[i].e_we)  check($sformatf("vec%0d_wdata", i), {24'd0, write_data}, {24'd0, vt[i].e_dat});
      if (vt[i].e_rsp) check($sformatf("vec%0d_rdata", i), {24'd0, rsp_rdata}, {24'd0, vt[i].e_dat});
    end
    @(posedge clk); #1;
    idle(2);

    // Test 4: back-to-back writes with req_valid held; FIFO must fill, then read all back.
    saw_full = 1'b0;
    for (int i = 1; i <= 8; i++) send(1'b1, 16'(i), 8'(8'h11 * i));
    drain();
    check("t4_fifo_filled", {31'd0, saw_full}, 32'd1);
    for (int i = 1; i <= 8; i++)
      check($sformatf("t4_sram_%0d", i), {24'd0, sram[i]}, {24'd0, 8'(8'h11 * i)});
    rc0 = rsp_count;
    for (int i = 1; i <= 8; i++) send(1'b0, 16'(i), 8'h00);
    drain();
    check("t4_rsp_count", rsp_count - rc0, 32'd8);

    // Test 5: write immediately followed by read of the same address.
    send(1'b1, 16'h0020, 8'h5A);
    send(1'b0, 16'h0020, 8'h00);
    drain();
    check("t5_rdata", {24'd0, last_rsp}, 32'h5A);

    // Test 6: reset while a read waits for data, with two more requests queued.
    send(1'b0, 16'h0030, 8'h00);
    send(1'b1, 16'h0031, 8'h01);
    send(1'b1, 16'h0032, 8'h02);
    req_valid = 1'b0;
    rc0 = rsp_count;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sc0 = strobe_count;
    @(negedge clk);
    check("t6_ready", {31'd0, req_ready}, 32'd1);
    check("t6_busy", {31'd0, busy}, 32'd0);
    check("t6_strobes", {30'd0, read_enable, write_enable_in}, 32'd0);
    @(posedge clk); #1;
    idle(15);
    check("t6_no_rsp", rsp_count - rc0, 32'd0);
    check("t6_no_strobe", strobe_count - sc0, 32'd0);
    check("t6_sram_untouched", {24'd0, sram.exists(16'h0031) ? sram[16'h0031] : init_val(16'h0031)},
          {24'd0, init_val(16'h0031)});

    // Randomized phase: random requests on a small address range, rare resets.
    for (int n = 0; n < 1500; n++) begin
      rst       = ($urandom_range(0, 199) == 0);
      req_valid = $urandom_range(0, 1);
      req_write = $urandom_range(0, 1);
      req_addr  = 16'($urandom_range(0, 15));
      req_wdata = 8'($urandom);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
